reg_mem_dp: RTL and testbench
=============================

REG_MEM_DP -- requirements
Module: reg_mem_dp

Interface
REQ-001 Parameter DATA_WIDTH, default 8: word width in bits.
REQ-002 Parameter ADDR_BITS, default 5: address width; depth = 2**ADDR_BITS (32 words).
REQ-003 Parameter INIT_VALUE, default 0: value written to every word by the clear sequence.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 clr  input  1  request to re-initialise the whole array, sampled in IDLE.
REQ-007 wr_en  input  1  write strobe.
REQ-008 wr_addr  input  ADDR_BITS  write address.
REQ-009 wr_data  input  DATA_WIDTH  write data.
REQ-010 rd_en  input  1  read strobe.
REQ-011 rd_addr  input  ADDR_BITS  read address.
REQ-012 rd_data  output  DATA_WIDTH  registered read data.
REQ-013 rd_valid  output  1  high for exactly one cycle when rd_data carries a fresh read result.
REQ-014 busy  output  1  high while the clear sequence runs; ports ignored while high.

Function
REQ-015 The block SHALL implement a two-state FSM, CLEAR and IDLE.
REQ-016 In CLEAR, each cycle SHALL write INIT_VALUE to mem[clr_cnt] and increment clr_cnt (ADDR_BITS wide).
REQ-017 CLEAR SHALL transition to IDLE on the edge that clears address 2**ADDR_BITS-1; total duration is exactly 2**ADDR_BITS cycles, and busy SHALL deassert on that same edge.
REQ-018 In CLEAR, wr_en, rd_en and clr SHALL be ignored; no write from the ports, rd_valid stays 0, rd_data holds.
REQ-019 In IDLE, clr=1 SHALL move to CLEAR with clr_cnt=0 and busy=1 on the next edge; any wr_en/rd_en in that cycle SHALL be dropped.
REQ-020 In IDLE, wr_en=1 SHALL write wr_data to mem[wr_addr] at the rising edge.
REQ-021 In IDLE, rd_en=1 SHALL load mem[rd_addr] into rd_data and set rd_valid=1 at the next rising edge (one-cycle latency).
REQ-022 When rd_en=0 or busy=1, rd_valid SHALL be 0 next cycle and rd_data SHALL hold its last value.
REQ-023 Simultaneous wr_en and rd_en to the same address SHALL be write-first: rd_data returns wr_data.
REQ-024 Simultaneous wr_en and rd_en to different addresses SHALL both complete in the same cycle.
REQ-025 Back-to-back reads on consecutive cycles SHALL each produce one rd_valid pulse, one cycle apart, with no bubble.
REQ-026 Addresses wrap naturally; every ADDR_BITS value is a valid address.

Reset
REQ-027 rst=1 at a rising edge SHALL force state=CLEAR, clr_cnt=0, busy=1, rd_valid=0, rd_data=0.
REQ-028 rst asserted mid-CLEAR SHALL restart the clear sequence from address 0.
REQ-029 rst SHALL take priority over clr, wr_en and rd_en in the same cycle.
REQ-030 Following rst deassertion, the array SHALL hold INIT_VALUE in all words once busy falls.

Structure
REQ-031 A shared package reg_mem_pkg SHALL hold the state enum (ST_CLEAR, ST_IDLE) and default parameter constants.
REQ-032 No sub-module; storage array, FSM and clear counter SHALL be inline in reg_mem_dp.
REQ-033 The storage array SHALL be a register array of 2**ADDR_BITS entries of DATA_WIDTH bits.

Verification (DATA_WIDTH=8, ADDR_BITS=5, INIT_VALUE=0)
REQ-034 Reset release -> busy high exactly 32 cycles; reads of addr 0..31 after busy falls return 0 with rd_valid one cycle after each rd_en.
REQ-035 Write value addr+10 to addr 0..31, then read 0..31 back-to-back -> rd_data = 10..41 on 32 consecutive cycles, rd_valid continuously high.
REQ-036 Same cycle wr_en addr 7 data 0xA5 and rd_en addr 7 -> next cycle rd_data=0xA5, rd_valid=1.
REQ-037 Fill with 0xFF, pulse clr with wr_en addr 3 data 0x11 same cycle -> write dropped, busy 32 cycles, all words read 0x00.
REQ-038 rst pulsed at clear cycle 10 -> busy stays high a further 32 cycles from restart; wr_en/rd_en during busy produce no rd_valid and no array change.

Source files
------------

// File: rtl/reg_mem_pkg.sv
// Purpose : shared types and default parameter constants for the reg_mem_dp
//           register-array memory.
// Contents: state_e      - controller states (clear sweep, normal operation)
//           DEF_*        - default values for the reg_mem_dp parameters
package reg_mem_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_ADDR_BITS  = 5;
    localparam int unsigned DEF_INIT_VALUE = 0;

endpackage : reg_mem_pkg

// File: rtl/reg_mem_dp.sv
// Purpose : register-array memory with one write port and one registered
//           read port, plus a self-timed clear sequence.
//           After reset, or on request, the controller sweeps every word to
//           INIT_VALUE, one word per cycle. The ports are ignored during the
//           sweep.
// Ports   : clk      - clock; all state changes on the rising edge
//           rst      - synchronous active-high reset; starts a clear sweep
//           clr      - request to re-initialise the array (sampled in IDLE)
//           wr_en    - write strobe
//           wr_addr  - write address
//           wr_data  - write data
//           rd_en    - read strobe
//           rd_addr  - read address
//           rd_data  - registered read data; holds between reads
//           rd_valid - one-cycle pulse when rd_data is a fresh read result
//           busy     - high while the clear sweep runs
module reg_mem_dp
    import reg_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_BITS  = DEF_ADDR_BITS,
    parameter int unsigned INIT_VALUE = DEF_INIT_VALUE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [ADDR_BITS-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_BITS-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;
    localparam logic [DATA_WIDTH-1:0] INIT_WORD = DATA_WIDTH'(INIT_VALUE);

    state_e                r_state;
    logic [ADDR_BITS-1:0]  r_clr_cnt;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic w_port_op;
    logic w_port_wr;
    logic w_port_rd;
    logic w_fwd;

    // Ports act only in IDLE, and a clear request drops any access in its cycle.
    assign w_port_op = (r_state == ST_IDLE) && !clr;
    assign w_port_wr = w_port_op && wr_en;
    assign w_port_rd = w_port_op && rd_en;
    // A write and a read to the same address return the new data (write-first).
    assign w_fwd     = wr_en && (wr_addr == rd_addr);

    // Controller: state, clear counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
            busy      <= 1'b1;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            rd_valid <= 1'b0;
            if (r_state == ST_CLEAR) begin
                r_clr_cnt <= r_clr_cnt + ADDR_BITS'(1);
                // Leave on the edge that clears the last word, so busy spans
                // exactly DEPTH cycles.
                if (&r_clr_cnt) begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            end else begin
                if (clr) begin
                    r_state   <= ST_CLEAR;
                    r_clr_cnt <= '0;
                    busy      <= 1'b1;
                end else if (w_port_rd) begin
                    rd_valid <= 1'b1;
                    rd_data  <= w_fwd ? wr_data : r_mem[rd_addr];
                end
            end
        end
    end

    // Storage: the clear sweep owns the write port while it runs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == ST_CLEAR) begin
                r_mem[r_clr_cnt] <= INIT_WORD;
            end else if (w_port_wr) begin
                r_mem[wr_addr] <= wr_data;
            end
        end
    end

endmodule : reg_mem_dp

// File: tb/tb_reg_mem_dp.sv
// Purpose : self-checking bench for reg_mem_dp (DATA_WIDTH=8, ADDR_BITS=5,
//           INIT_VALUE=0). A behavioural model tracks the array and outputs;
//           every cycle the outputs are compared against it, and directed
//           scenarios add literal expectations.
module tb_reg_mem_dp;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 32;
    localparam logic [DW-1:0] INIT = 8'h00;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_mem_dp #(
        .DATA_WIDTH (DW),
        .ADDR_BITS  (AW),
        .INIT_VALUE (0)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy)
    );

    // Behavioural model: clearing is "words still to clear", reads see the
    // array as it stands, plus the write when both hit the same address.
    logic [DW-1:0] m_mem [DEPTH];
    int            m_left  = 0;
    bit            m_busy  = 1'b0;
    bit            m_valid = 1'b0;
    logic [DW-1:0] m_data  = '0;
    bit            m_init  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_init  = 1'b1;
            m_busy  = 1'b1;
            m_left  = DEPTH;
            m_valid = 1'b0;
            m_data  = '0;
        end else if (m_busy) begin
            m_mem[DEPTH - m_left] = INIT;
            m_left  = m_left - 1;
            m_busy  = (m_left != 0);
            m_valid = 1'b0;
        end else if (clr) begin
            m_busy  = 1'b1;
            m_left  = DEPTH;
            m_valid = 1'b0;
        end else begin
            m_valid = rd_en;
            if (rd_en)
                m_data = (wr_en && wr_addr == rd_addr) ? wr_data : m_mem[rd_addr];
            if (wr_en)
                m_mem[wr_addr] = wr_data;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Advance one cycle and compare the outputs against the model.
    task automatic tick();
        @(negedge clk);
        if (m_init) begin
            check("model_busy",     32'(busy),     32'(m_busy));
            check("model_rd_valid", 32'(rd_valid), 32'(m_valid));
            check("model_rd_data",  32'(rd_data),  32'(m_data));
        end
    endtask

    task automatic idle_inputs();
        clr     = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
    endtask

    task automatic noise_inputs();
        clr     = 1'($urandom_range(0, 1));
        wr_en   = 1'($urandom_range(0, 1));
        rd_en   = 1'($urandom_range(0, 1));
        wr_addr = AW'($urandom);
        wr_data = DW'($urandom | 1);
        rd_addr = AW'($urandom);
    endtask

    // Count cycles with busy high from the current sample; bounded wait.
    task automatic count_busy(input string name, input bit noise);
        int n = 0;
        while (busy && n < 100) begin
            n++;
            if (noise) noise_inputs();
            tick();
        end
        idle_inputs();
        check(name, 32'(n), 32'd32);
    endtask

    task automatic read_all(input string name, input logic [DW-1:0] exp_w [DEPTH]);
        for (int i = 0; i < DEPTH; i++) begin
            rd_en   = 1'b1;
            rd_addr = AW'(i);
            tick();
            check({name, "_valid"}, 32'(rd_valid), 32'd1);
            check(name, 32'(rd_data), 32'(exp_w[i]));
        end
        rd_en = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] exp_w [DEPTH];

        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        check("reset_busy",     32'(busy),     32'd1);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_rd_data",  32'(rd_data),  32'd0);

        // Clear sweep after reset release, then the whole array reads INIT.
        rst = 1'b0;
        count_busy("reset_busy_cycles", 1'b0);
        for (int i = 0; i < DEPTH; i++) exp_w[i] = INIT;
        read_all("init_read", exp_w);

        // addr+10 pattern, read back-to-back.
        for (int i = 0; i < DEPTH; i++) begin
            wr_en   = 1'b1;
            wr_addr = AW'(i);
            wr_data = DW'(i + 10);
            tick();
        end
        wr_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) exp_w[i] = DW'(i + 10);
        read_all("pattern_read", exp_w);

        // Same-address write and read: write-first.
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 8'hA5;
        rd_en = 1'b1; rd_addr = 5'd7;
        tick();
        check("fwd_valid", 32'(rd_valid), 32'd1);
        check("fwd_data",  32'(rd_data),  32'hA5);

        // Different addresses in the same cycle both complete.
        wr_addr = 5'd8; wr_data = 8'h3C; rd_addr = 5'd9;
        tick();
        check("dual_rd_data", 32'(rd_data), 32'd19);
        wr_en = 1'b0; rd_addr = 5'd8;
        tick();
        check("dual_wr_data", 32'(rd_data), 32'h3C);
        rd_en = 1'b0;
        tick();
        check("idle_valid", 32'(rd_valid), 32'd0);
        check("idle_hold",  32'(rd_data),  32'h3C);

        // Fill with 0xFF, then clr with a simultaneous write that must drop.
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = 8'hFF;
            tick();
        end
        clr = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 8'h11;
        rd_en = 1'b1; rd_addr = 5'd4;
        tick();
        idle_inputs();
        check("clr_busy", 32'(busy), 32'd1);
        check("clr_no_rd_valid", 32'(rd_valid), 32'd0);
        count_busy("clr_busy_cycles", 1'b1);
        for (int i = 0; i < DEPTH; i++) exp_w[i] = 8'h00;
        read_all("clr_read", exp_w);

        // Rewrite non-zero data, start a clear, reset at clear cycle 10.
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = 8'h5A;
            tick();
        end
        idle_inputs();
        clr = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            noise_inputs();
            tick();
        end
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_busy("rst_mid_clear_cycles", 1'b1);
        read_all("rst_mid_clear_read", exp_w);

        // Randomised traffic with occasional clr and rst.
        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(0, 299) == 0);
            clr     = ($urandom_range(0, 79) == 0);
            wr_en   = 1'($urandom_range(0, 1));
            rd_en   = 1'($urandom_range(0, 1));
            wr_addr = AW'($urandom_range(0, 7));
            rd_addr = AW'($urandom_range(0, 7));
            wr_data = DW'($urandom);
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_reg_mem_dp
